// File: rtl/fetch_unit.sv
// Sequential instruction fetch feeding a small {instruction, pc} buffer.
// Optional flush/restart port pair enabled by `define FETCH_REDIRECT_EN.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
`ifdef FETCH_REDIRECT_EN
    ,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT
`ifdef FETCH_REDIRECT_EN
        ,
        S_DRAIN
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    fpc_q, fpc_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    ins_q [DEPTH];
    logic [15:0]    pcs_q [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic           push;
    logic           pop;
    logic           flush;
`ifdef FETCH_REDIRECT_EN
    logic [15:0]    drain_addr_q, drain_addr_d;
`endif

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (tail_q == PW'(gi));
    end

    always_comb begin
        pop       = (count_q != '0) && ir_ready;
        push      = 1'b0;
        flush     = 1'b0;
        state_d   = state_q;
        fpc_d     = fpc_q;
        imem_req  = 1'b0;
        imem_addr = fpc_q;
`ifdef FETCH_REDIRECT_EN
        drain_addr_d = drain_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // resetn gate keeps the request low while reset is held
                if (resetn && (pop || (count_q < FULL))) begin
                    imem_req = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    push    = 1'b1;
                    fpc_d   = fpc_q + 16'd2;
                    state_d = S_IDLE;
                end
            end
`ifdef FETCH_REDIRECT_EN
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef FETCH_REDIRECT_EN
        if (redirect) begin
            flush = 1'b1;
            push  = 1'b0;
            fpc_d = redirect_pc & 16'hFFFE;
            case (state_q)
                S_IDLE: begin
                    imem_req = 1'b0;
                    state_d  = S_IDLE;
                end
                S_WAIT: begin
                    // the in-flight word must still be drained at its own address
                    if (imem_ack) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_DRAIN;
                        drain_addr_d = fpc_q;
                    end
                end
                default: ;
            endcase
        end
`endif
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
`ifdef FETCH_REDIRECT_EN
            drain_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
`ifdef FETCH_REDIRECT_EN
            drain_addr_q <= drain_addr_d;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ins_q[i] <= '0;
                pcs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    ins_q[i] <= imem_rdata;
                    pcs_q[i] <= fpc_q;
                end
            end
        end
    end

    assign ir_valid = (count_q != '0);
    assign ir       = ins_q[head_q];
    assign ir_pc    = pcs_q[head_q];

endmodule
